// File: rtl/adc_serial_reader_if.sv
// Serial ADC reader bundle: run enable, ADC pins and the sample port.
// master is the reader side, slave is the consumer/ADC side.
interface adc_serial_reader_if #(
  parameter int DATA_BITS = 12
);
  logic                 run;
  logic                 adc_sdata;
  logic                 adc_sclk;
  logic                 adc_cs_n;
  logic [DATA_BITS-1:0] dout;
  logic                 dout_valid;
  logic                 lead_err;
  logic                 busy;

  modport master (
    input  run,
    input  adc_sdata,
    output adc_sclk,
    output adc_cs_n,
    output dout,
    output dout_valid,
    output lead_err,
    output busy
  );

  modport slave (
    output run,
    output adc_sdata,
    input  adc_sclk,
    input  adc_cs_n,
    input  dout,
    input  dout_valid,
    input  lead_err,
    input  busy
  );
endinterface

// File: rtl/adc_serial_reader.sv
// Frame reader for a 16-clock MSB-first serial ADC with 4 leading zeros.
// Drives cs_n/sclk, shifts the data line in, emits one sample per frame.
module adc_serial_reader #(
  parameter int CLK_DIV      = 25,
  parameter int FRAME_BITS   = 16,
  parameter int LEAD_BITS    = 4,
  parameter int DATA_BITS    = 12,
  parameter int QUIET_CYCLES = 174
) (
  input  logic                  clk50,
  input  logic                  rst_n,
  adc_serial_reader_if.master   bus
);

  localparam int CNT_MAX = (CLK_DIV > QUIET_CYCLES) ?
                           CLK_DIV : QUIET_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);

  localparam logic [CW-1:0] DIV_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] QUIET_END = CW'(QUIET_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    QUIET
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bits;
  logic [FRAME_BITS-1:0] shift;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bits           <= '0;
      shift          <= '0;
      bus.adc_cs_n   <= 1'b1;
      bus.adc_sclk   <= 1'b1;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.lead_err   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.dout_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.run) begin
            state        <= SETUP;
            bus.adc_cs_n <= 1'b0;
            bus.busy     <= 1'b1;
            cnt          <= '0;
            bits         <= '0;
            shift        <= '0;
          end
        end
        SETUP: begin
          if (cnt == DIV_END) begin
            state        <= SHIFT;
            bus.adc_sclk <= 1'b0;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != DIV_END) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            // sample on the edge that raises sclk
            if (!bus.adc_sclk) begin
              bus.adc_sclk <= 1'b1;
              shift <= {shift[FRAME_BITS-2:0], bus.adc_sdata};
              bits  <= bits + 1'b1;
            end else if (bits == LAST_BIT) begin
              state          <= DONE;
              bus.adc_cs_n   <= 1'b1;
              bus.dout       <= shift[DATA_BITS-1:0];
              bus.lead_err   <= |shift[DATA_BITS +: LEAD_BITS];
              bus.dout_valid <= 1'b1;
            end else begin
              bus.adc_sclk <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= QUIET;
          cnt   <= '0;
        end
        QUIET: begin
          if (cnt != QUIET_END) begin
            cnt <= cnt + 1'b1;
          end else if (bus.run) begin
            state        <= SETUP;
            bus.adc_cs_n <= 1'b0;
            cnt          <= '0;
            bits         <= '0;
            shift        <= '0;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
